// File: rtl/pe_row_scheduler.sv
// pe_row_scheduler: row sequencer for one attention PE.
// Walks the query rows of a tile. Each row issues one Q read, streams NUM_KV
// K/V reads (the last one is marked), then waits for the PE output to be
// accepted by OSRAM. Carries no vector data.
// Optional build macro PE_SCHED_PERF_EN adds the stall_cycles counter port.
module pe_row_scheduler #(
    parameter int NUM_Q     = 64,
    parameter int NUM_KV    = 64,
    parameter int Q_ADDR_W  = (NUM_Q  > 1) ? $clog2(NUM_Q)  : 1,
    parameter int KV_ADDR_W = (NUM_KV > 1) ? $clog2(NUM_KV) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 q_rd_vld,
    input  logic                 q_rd_rdy,
    output logic [Q_ADDR_W-1:0]  q_rd_addr,
    output logic                 kv_rd_vld,
    input  logic                 kv_rd_rdy,
    output logic [KV_ADDR_W-1:0] kv_rd_addr,
    output logic                 kv_last,
    input  logic                 o_vld,
    input  logic                 o_rdy,
    output logic [Q_ADDR_W-1:0]  o_wr_addr
`ifdef PE_SCHED_PERF_EN
    ,
    output logic [31:0]          stall_cycles
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_Q,
        S_STREAM_KV,
        S_DRAIN,
        S_DONE
    } state_e;

    localparam logic [Q_ADDR_W-1:0]  Q_LAST  = Q_ADDR_W'(NUM_Q - 1);
    localparam logic [KV_ADDR_W-1:0] KV_LAST = KV_ADDR_W'(NUM_KV - 1);

    state_e                state_q, state_d;
    logic [Q_ADDR_W-1:0]   q_cnt_q, q_cnt_d;
    logic [KV_ADDR_W-1:0]  kv_cnt_q, kv_cnt_d;

    // State and row/beat counters.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            q_cnt_q  <= '0;
            kv_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            q_cnt_q  <= q_cnt_d;
            kv_cnt_q <= kv_cnt_d;
        end
    end

    // Next-state and counter update; abort overrides every transition.
    // NOTE: every signal gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        q_cnt_d  = q_cnt_q;
        kv_cnt_d = kv_cnt_q;
        if (abort) begin
            state_d  = S_IDLE;
            q_cnt_d  = '0;
            kv_cnt_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d  = S_LOAD_Q;
                        q_cnt_d  = '0;
                        kv_cnt_d = '0;
                    end
                end
                S_LOAD_Q: begin
                    if (q_rd_rdy) state_d = S_STREAM_KV;
                end
                S_STREAM_KV: begin
                    if (kv_rd_rdy) begin
                        if (kv_cnt_q == KV_LAST) begin
                            kv_cnt_d = '0;
                            state_d  = S_DRAIN;
                        end else begin
                            kv_cnt_d = kv_cnt_q + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    // o_vld seen in any other state is a protocol error and is ignored.
                    if (o_vld && o_rdy) begin
                        if (q_cnt_q == Q_LAST) begin
                            state_d = S_DONE;
                        end else begin
                            q_cnt_d = q_cnt_q + 1'b1;
                            state_d = S_LOAD_Q;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    q_cnt_d = '0;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs decode registered state only; no ready/valid input reaches them.
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign q_rd_vld   = (state_q == S_LOAD_Q);
    assign kv_rd_vld  = (state_q == S_STREAM_KV);
    assign kv_last    = (state_q == S_STREAM_KV) && (kv_cnt_q == KV_LAST);
    assign q_rd_addr  = q_cnt_q;
    assign kv_rd_addr = kv_cnt_q;
    assign o_wr_addr  = q_cnt_q;

`ifdef PE_SCHED_PERF_EN
    logic [31:0] stall_q, stall_d;

    // Saturating count of K/V request cycles refused by the SRAM.
    always_comb begin
        stall_d = stall_q;
        if (abort || (state_q == S_IDLE && start)) begin
            stall_d = '0;
        end else if (state_q == S_STREAM_KV && !kv_rd_rdy && stall_q != '1) begin
            stall_d = stall_q + 32'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_q <= '0;
        else     stall_q <= stall_d;
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_pe_row_scheduler.sv
// tb_pe_row_scheduler: randomized self-checking bench for pe_row_scheduler.
// A tile is described as the ordered list of transactions it must produce
// (Q row r, K/V beats 0..NUM_KV-1 with last marker, O row r, ..., done); the
// observed handshakes are collected and compared against that list, along
// with latency, hold-while-stalled and reset/abort rules.
module tb_pe_row_scheduler;

    localparam int NQ  = 2;
    localparam int NKV = 4;
    localparam int QW  = 1;
    localparam int KW  = 2;

    localparam logic [31:0] EV_Q    = 32'h1000_0000;
    localparam logic [31:0] EV_KV   = 32'h2000_0000;
    localparam logic [31:0] EV_O    = 32'h3000_0000;
    localparam logic [31:0] EV_DONE = 32'h4000_0000;

    logic          clk = 1'b0;
    logic          rst, start, abort;
    logic          busy, done;
    logic          q_rd_vld, q_rd_rdy;
    logic [QW-1:0] q_rd_addr;
    logic          kv_rd_vld, kv_rd_rdy;
    logic [KW-1:0] kv_rd_addr;
    logic          kv_last;
    logic          o_vld, o_rdy;
    logic [QW-1:0] o_wr_addr;
`ifdef PE_SCHED_PERF_EN
    logic [31:0]   stall_cycles;
`endif

    int checks = 0;
    int passed = 0;

    pe_row_scheduler #(
        .NUM_Q(NQ), .NUM_KV(NKV), .Q_ADDR_W(QW), .KV_ADDR_W(KW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .busy(busy), .done(done),
        .q_rd_vld(q_rd_vld), .q_rd_rdy(q_rd_rdy), .q_rd_addr(q_rd_addr),
        .kv_rd_vld(kv_rd_vld), .kv_rd_rdy(kv_rd_rdy), .kv_rd_addr(kv_rd_addr),
        .kv_last(kv_last),
        .o_vld(o_vld), .o_rdy(o_rdy), .o_wr_addr(o_wr_addr)
`ifdef PE_SCHED_PERF_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Advance one clock and land 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 1'b0; abort = 1'b0;
        q_rd_rdy = 1'b0; kv_rd_rdy = 1'b0; o_vld = 1'b0; o_rdy = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if ({busy, done, q_rd_vld, kv_rd_vld, kv_last, q_rd_addr, kv_rd_addr, o_wr_addr} !== '0)
                $display("FAIL reset_idle cycle %0d: busy=%b done=%b qv=%b kvv=%b last=%b qa=%0h kva=%0h oa=%0h, required all 0",
                         i, busy, done, q_rd_vld, kv_rd_vld, kv_last, q_rd_addr, kv_rd_addr, o_wr_addr);
            else passed++;
        end
`ifdef PE_SCHED_PERF_EN
        checks++;
        if (stall_cycles !== 32'd0) $display("FAIL reset_stall: got %0d required 0", stall_cycles);
        else passed++;
`endif
    endtask

    // Run one whole tile under randomized handshakes and check it against
    // the expected transaction list.
    task automatic run_tile(input string name, input int q_pct, input int kv_pct, input int o_pct,
                            input int o_dly_min, input int o_dly_max, input int stall_idx,
                            input int o_hold, input bit stray);
        logic [31:0]   exp_ev[$];
        logic [31:0]   obs_ev[$];
        logic [KW-1:0] prev_kv_addr;
        int  stalls = 0, drain_cnt = 0, stall_left = 3, o_seen = 0, o_dly;
        bit  finished = 0, prev_stall = 0, after_q = 0, after_o = 0, prev_oblock = 0, drain;

        for (int r = 0; r < NQ; r++) begin
            exp_ev.push_back(EV_Q | 32'(r));
            for (int k = 0; k < NKV; k++)
                exp_ev.push_back(EV_KV | ((k == NKV - 1) ? 32'h100 : 32'h0) | 32'(k));
            exp_ev.push_back(EV_O | 32'(r));
        end
        exp_ev.push_back(EV_DONE);

        idle_inputs();
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (q_rd_vld !== 1'b1 || q_rd_addr !== '0)
            $display("FAIL %s start_latency: q_rd_vld=%b q_rd_addr=%0h required 1/0", name, q_rd_vld, q_rd_addr);
        else passed++;

        o_dly = $urandom_range(o_dly_max, o_dly_min);
        for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
            if (prev_stall) begin
                checks++;
                if (kv_rd_vld !== 1'b1 || kv_rd_addr !== prev_kv_addr)
                    $display("FAIL %s kv_hold: kv_rd_vld=%b addr=%0h required 1/%0h", name, kv_rd_vld, kv_rd_addr, prev_kv_addr);
                else passed++;
            end
            if (after_q) begin
                checks++;
                if (kv_rd_vld !== 1'b1 || kv_rd_addr !== '0)
                    $display("FAIL %s q_to_kv: kv_rd_vld=%b addr=%0h required 1/0", name, kv_rd_vld, kv_rd_addr);
                else passed++;
            end
            if (prev_oblock) begin
                checks++;
                if (busy !== 1'b1 || q_rd_vld !== 1'b0 || kv_rd_vld !== 1'b0 || done !== 1'b0)
                    $display("FAIL %s drain_hold: busy=%b qv=%b kvv=%b done=%b required 1/0/0/0", name, busy, q_rd_vld, kv_rd_vld, done);
                else passed++;
            end
            if (after_o) begin
                checks++;
                if (o_seen == NQ) begin
                    if (done !== 1'b1) $display("FAIL %s o_to_done: done=%b required 1", name, done);
                    else passed++;
                end else begin
                    if (q_rd_vld !== 1'b1 || q_rd_addr !== QW'(o_seen))
                        $display("FAIL %s o_to_q: q_rd_vld=%b addr=%0h required 1/%0h", name, q_rd_vld, q_rd_addr, o_seen);
                    else passed++;
                end
            end
            prev_stall = 0; after_q = 0; after_o = 0; prev_oblock = 0;

            if (done === 1'b1) begin
                obs_ev.push_back(EV_DONE);
                finished = 1;
            end else begin
                drain = busy && !q_rd_vld && !kv_rd_vld;
                drain_cnt = drain ? drain_cnt + 1 : 0;
                q_rd_rdy = ($urandom % 100) < q_pct;
                if (stall_idx >= 0 && kv_rd_vld && kv_rd_addr == KW'(stall_idx) && stall_left > 0) begin
                    kv_rd_rdy = 1'b0;
                    stall_left--;
                end else begin
                    kv_rd_rdy = ($urandom % 100) < kv_pct;
                end
                if (drain) begin
                    o_vld = drain_cnt > o_dly;
                    o_rdy = (drain_cnt > o_hold) ? (($urandom % 100) < o_pct) : 1'b0;
                end else begin
                    o_vld = stray ? ($urandom % 3 == 0) : 1'b0;
                    o_rdy = $urandom % 2;
                end
                start = stray && ($urandom % 6 == 0);

                if (q_rd_vld && q_rd_rdy) begin
                    obs_ev.push_back(EV_Q | 32'(q_rd_addr));
                    after_q = 1;
                end
                if (kv_rd_vld) begin
                    if (kv_rd_rdy) begin
                        obs_ev.push_back(EV_KV | (kv_last ? 32'h100 : 32'h0) | 32'(kv_rd_addr));
                    end else begin
                        stalls++;
                        prev_stall = 1;
                        prev_kv_addr = kv_rd_addr;
                    end
                end
                if (drain && o_vld) begin
                    if (o_rdy) begin
                        obs_ev.push_back(EV_O | 32'(o_wr_addr));
                        o_seen++;
                        after_o = 1;
                        o_dly = $urandom_range(o_dly_max, o_dly_min);
                    end else begin
                        prev_oblock = 1;
                    end
                end
                step();
            end
        end
        idle_inputs();

        checks++;
        if (!finished) begin
            $display("FAIL %s timeout: no done within 2000 cycles, required done", name);
            rst = 1'b1; step(); rst = 1'b0; step();
        end else begin
            passed++;
            step();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0)
                $display("FAIL %s done_pulse: done=%b busy=%b required 0/0", name, done, busy);
            else passed++;
        end

        checks++;
        if (obs_ev.size() != exp_ev.size())
            $display("FAIL %s event_count: got %0d required %0d", name, obs_ev.size(), exp_ev.size());
        else passed++;
        for (int i = 0; i < exp_ev.size() && i < obs_ev.size(); i++) begin
            checks++;
            if (obs_ev[i] !== exp_ev[i])
                $display("FAIL %s event[%0d]: got %h required %h", name, i, obs_ev[i], exp_ev[i]);
            else passed++;
        end
`ifdef PE_SCHED_PERF_EN
        checks++;
        if (stall_cycles !== 32'(stalls))
            $display("FAIL %s stall_cycles: got %0d required %0d", name, stall_cycles, stalls);
        else passed++;
`endif
    endtask

    task automatic test_basic();
        run_tile("basic", 100, 100, 100, 5, 5, -1, 0, 1'b0);
    endtask

    task automatic test_kv_stall();
        run_tile("kv_stall", 100, 100, 100, 2, 2, 2, 0, 1'b0);
`ifdef PE_SCHED_PERF_EN
        checks++;
        if (stall_cycles !== 32'd3) $display("FAIL kv_stall_three: got %0d required 3", stall_cycles);
        else passed++;
`endif
    endtask

    task automatic test_drain_hold();
        run_tile("drain_hold", 100, 100, 100, 0, 0, -1, 4, 1'b0);
    endtask

    task automatic test_start_ignored();
        run_tile("start_ignored", 100, 100, 100, 1, 3, -1, 0, 1'b1);
    endtask

    task automatic test_abort();
        bit hit = 0;
        idle_inputs();
        start = 1'b1;
        step();
        start = 1'b0; q_rd_rdy = 1'b1; kv_rd_rdy = 1'b1;
        for (int i = 0; i < 50 && !hit; i++) begin
            if (kv_rd_vld === 1'b1 && kv_rd_addr === 2'd1) hit = 1;
            else step();
        end
        checks++;
        if (!hit) $display("FAIL abort_reach: kv index 1 not reached, required reach");
        else passed++;
        abort = 1'b1;
        kv_rd_rdy = $urandom % 2;
        step();
        abort = 1'b0; kv_rd_rdy = 1'b0; q_rd_rdy = 1'b0;
        checks++;
        if ({busy, done, q_rd_vld, kv_rd_vld, kv_last, q_rd_addr, kv_rd_addr} !== '0)
            $display("FAIL abort_idle: busy=%b done=%b qv=%b kvv=%b qa=%0h kva=%0h required all 0",
                     busy, done, q_rd_vld, kv_rd_vld, q_rd_addr, kv_rd_addr);
        else passed++;
`ifdef PE_SCHED_PERF_EN
        checks++;
        if (stall_cycles !== 32'd0) $display("FAIL abort_stall_clear: got %0d required 0", stall_cycles);
        else passed++;
`endif
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0)
                $display("FAIL abort_no_done cycle %0d: done=%b busy=%b required 0/0", i, done, busy);
            else passed++;
        end
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        checks++;
        if (busy !== 1'b0) $display("FAIL abort_over_start: busy=%b required 0", busy);
        else passed++;
        run_tile("after_abort", 100, 70, 100, 0, 2, -1, 0, 1'b0);
    endtask

    task automatic test_rst_mid_drain();
        bit hit = 0;
        idle_inputs();
        start = 1'b1;
        step();
        start = 1'b0; q_rd_rdy = 1'b1; kv_rd_rdy = 1'b1;
        for (int i = 0; i < 50 && !hit; i++) begin
            if (busy === 1'b1 && !q_rd_vld && !kv_rd_vld && !done) hit = 1;
            else step();
        end
        checks++;
        if (!hit) $display("FAIL rst_reach_drain: DRAIN not reached, required reach");
        else passed++;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, q_rd_vld, kv_rd_vld, kv_last, q_rd_addr, kv_rd_addr, o_wr_addr} !== '0)
            $display("FAIL rst_async: busy=%b done=%b qv=%b kvv=%b oa=%0h required all 0 before edge",
                     busy, done, q_rd_vld, kv_rd_vld, o_wr_addr);
        else passed++;
        step();
        rst = 1'b0;
        o_vld = 1'b1; o_rdy = 1'b1;
        repeat (3) step();
        checks++;
        if (busy !== 1'b0 || q_rd_vld !== 1'b0)
            $display("FAIL rst_stays_idle: busy=%b qv=%b required 0/0", busy, q_rd_vld);
        else passed++;
        idle_inputs();
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            run_tile("random", $urandom_range(100, 30), $urandom_range(100, 30), $urandom_range(100, 30),
                     0, $urandom_range(6, 0), $urandom_range(NKV - 1, 0), $urandom_range(3, 0), 1'b1);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_basic();
        test_kv_stall();
        test_drain_hold();
        test_abort();
        test_start_ignored();
        test_rst_mid_drain();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pe_row_scheduler.md
# pe_row_scheduler

Sequencer for one AURA backend PE. It walks the query rows of an attention tile. For each row it issues one Q read, then streams NUM_KV K/V reads with a last-beat marker, then waits for the PE's normalized output vector to be accepted by OSRAM before moving on. It sits between the Q/K/V SRAM read ports and the PE input handshakes, and generates the OSRAM write index. It carries no vector data.

## Interface
- NUM_Q, default 64: query rows per tile; must be ≥1.
- NUM_KV, default 64: key/value vectors per row; must be ≥1.
- Q_ADDR_W, default $clog2(NUM_Q) (min 1): Q/O index width.
- KV_ADDR_W, default $clog2(NUM_KV) (min 1): K/V index width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin tile; sampled only in IDLE
- abort  in  1  synchronous abandon of the current tile
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on tile completion
- q_rd_vld  out  1  Q read request valid
- q_rd_rdy  in  1  Q read request accepted
- q_rd_addr  out  Q_ADDR_W  current row index
- kv_rd_vld  out  1  K/V read request valid
- kv_rd_rdy  in  1  K/V read request accepted
- kv_rd_addr  out  KV_ADDR_W  current K/V index
- kv_last  out  1  high with kv_rd_vld on index NUM_KV-1
- o_vld  in  1  PE output_valid (observed)
- o_rdy  in  1  OSRAM ready (observed)
- o_wr_addr  out  Q_ADDR_W  OSRAM row index for the pending output
- stall_cycles  out  32  (PE_SCHED_PERF_EN only) cycles in STREAM_KV with kv_rd_vld && !kv_rd_rdy

## Operation
- FSM states: IDLE, LOAD_Q, STREAM_KV, DRAIN, DONE.
- IDLE:
  - start=1 → LOAD_Q, q_cnt=0, kv_cnt=0.
  - start=0 → stay.
- LOAD_Q:
  - q_rd_vld=1, q_rd_addr=q_cnt.
  - On q_rd_vld && q_rd_rdy → STREAM_KV.
- STREAM_KV:
  - kv_rd_vld=1, kv_rd_addr=kv_cnt, kv_last=(kv_cnt==NUM_KV-1).
  - Each handshake: kv_cnt++.
  - Handshake with kv_last: kv_cnt=0 → DRAIN.
- DRAIN:
  - No requests are issued. o_wr_addr=q_cnt.
  - On o_vld && o_rdy: if q_cnt==NUM_Q-1 → DONE; else q_cnt++ → LOAD_Q.
- DONE: done=1 for exactly one cycle → IDLE.
- abort=1 in any state → IDLE on the next edge; counters cleared; no done pulse. abort has priority over every transition, including start.
- start while busy is ignored.
- Counters do not wrap inside a tile. q_cnt and kv_cnt never exceed NUM_Q-1 and NUM_KV-1.
- o_vld outside DRAIN is a protocol error. It is ignored, with no state change.
- NUM_KV=1: kv_last is high on the single beat of each row.

## Timing
- Reset values:
  - state=IDLE, busy=0, done=0
  - q_rd_vld=0, kv_rd_vld=0, kv_last=0
  - all address outputs 0
  - stall_cycles=0
- All outputs are registered or decoded from registered state only. There is no combinational path from any *_rdy or o_vld input to any output.
- start→q_rd_vld: 1 cycle.
- q handshake → first kv_rd_vld: next cycle.
- Back-to-back K/V handshakes sustain 1 beat/cycle. kv_rd_vld stays high and addr is stable while rdy=0.
- Final output handshake → next row's q_rd_vld, or done: next cycle.
- Minimum tile length: NUM_Q*(NUM_KV+2) cycles plus PE drain latency plus 2.
- Reset asserted mid-tile: all outputs return to reset values immediately (async). Operation resumes only after a new start.

## Configuration
- PE_SCHED_PERF_EN:
  - Defined: stall_cycles port present. It saturates at 2^32-1 and clears on start accept and on abort.
  - Undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset then idle: rst pulse, start=0 for 10 cycles → busy=0, all valids 0, addrs 0.
- NUM_Q=2, NUM_KV=4, all rdy=1, o_vld asserted 5 cycles after each kv_last → Q addrs 0,1; kv addrs 0..3 twice; kv_last on beat 3; o_wr_addr 0 then 1; done one cycle after the second o handshake.
- kv_rd_rdy low for 3 cycles at kv index 2 → addr holds 2, kv_rd_vld stays 1, no skipped or duplicated index. With PE_SCHED_PERF_EN, stall_cycles=3.
- o_rdy=0 while o_vld=1 for 4 cycles in DRAIN → state stays DRAIN, q_rd_vld=0, advances only after o_rdy=1.
- abort during STREAM_KV at kv index 1 → IDLE next cycle, no done. A following start begins at q_rd_addr=0.
- start pulsed during STREAM_KV, and async rst mid-DRAIN → start ignored; rst forces busy=0 without a clock edge.
